// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier that retires one digit per clock.
// The accumulator is wide enough for the W+2-bit extended operands, so one core serves both signed and unsigned modes.
module booth_mul_seq #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int N  = W / 2 + 1;
  localparam int AW = 2 * W + 2;
  localparam int CW = $clog2(N);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // BUSY  | one setup cycle (ld), then one Booth digit per clock
  // DONE  | product on p, waiting for out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [W-1:0]    xr, yr;
  logic            sr, ld;
  logic [AW-1:0]   mcand, hm, acc;
  logic [W+2:0]    yq;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   mag, pp, wt;
  logic            neg;

  // hm masks the bits at and above the current digit weight, so a negative
  // digit is ~X there plus a single carry-in at weight 4^i.
  always_comb begin
    neg = 1'b0;
    mag = '0;
    case (yq[2:0])
      3'b001, 3'b010: mag = mcand;
      3'b011:         mag = mcand << 1;
      3'b100:         begin mag = mcand << 1; neg = 1'b1; end
      3'b101, 3'b110: begin mag = mcand;      neg = 1'b1; end
      default:        mag = '0;
    endcase
    wt = hm & ~(hm << 1);
    pp = neg ? (~mag & hm) : mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ld    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            sr    <= is_signed;
            ld    <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ld) begin
            // Extension happens one cycle after capture to keep the input path short.
            mcand <= {{(W + 2){sr & xr[W-1]}}, xr};
            yq    <= {{2{sr & yr[W-1]}}, yr, 1'b0};
            hm    <= '1;
            ld    <= 1'b0;
          end else begin
            acc   <= acc + pp + (neg ? wt : '0);
            mcand <= mcand << 2;
            hm    <= hm << 2;
            yq    <= yq >> 2;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign p         = acc[2*W-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq at W=8, 16 and 64 against a plain-arithmetic product model.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic iv8, or8, s8, ir8, ov8, b8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;
  logic iv16, or16, s16, ir16, ov16, b16;
  logic [15:0] x16, y16;
  logic [31:0] p16;
  logic iv64, or64, s64, ir64, ov64, b64;
  logic [63:0]  x64, y64;
  logic [127:0] p64;

  booth_mul_seq #(.W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(b8));
  booth_mul_seq #(.W(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .p(p16), .busy(b16));
  booth_mul_seq #(.W(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .x(x64), .y(y64),
    .is_signed(s64), .out_valid(ov64), .out_ready(or64), .p(p64), .busy(b64));

  function automatic logic [127:0] ref_mul(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic s);
    logic [127:0] ea, eb, lo, m2;
    lo = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & lo;
    eb = {64'd0, b} & lo;
    if (s && ea[w-1]) ea = ea | ~lo;
    if (s && eb[w-1]) eb = eb | ~lo;
    m2 = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    return (ea * eb) & m2;
  endfunction

  function automatic logic st_ir(input int w);
    case (w) 8: return ir8; 16: return ir16; default: return ir64; endcase
  endfunction
  function automatic logic st_ov(input int w);
    case (w) 8: return ov8; 16: return ov16; default: return ov64; endcase
  endfunction
  function automatic logic st_busy(input int w);
    case (w) 8: return b8; 16: return b16; default: return b64; endcase
  endfunction
  function automatic logic [127:0] st_p(input int w);
    case (w) 8: return 128'(p8); 16: return 128'(p16); default: return p64; endcase
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic s);
    case (w)
      8:       begin iv8  = v; x8  = a[7:0];  y8  = b[7:0];  s8  = s; end
      16:      begin iv16 = v; x16 = a[15:0]; y16 = b[15:0]; s16 = s; end
      default: begin iv64 = v; x64 = a;       y64 = b;       s64 = s; end
    endcase
  endtask

  task automatic drive_or(input int w, input logic v);
    case (w) 8: or8 = v; 16: or16 = v; default: or64 = v; endcase
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation at a negedge, measures latency, holds backpressure, then drains.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                        input int gap, input int hold, input string tag);
    logic [127:0] expv;
    int edges;
    expv = ref_mul(w, a, b, s);
    repeat (gap) @(negedge clk);
    drive_in(w, 1'b1, a, b, s);
    chk({tag, " in_ready"}, 128'(st_ir(w)), 128'd1);
    @(negedge clk);
    drive_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, ~s);
    chk({tag, " busy"}, 128'(st_busy(w)), 128'd1);
    edges = 0;
    while (!st_ov(w) && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, " latency"}, 128'(edges), 128'(w / 2 + 2));
    chk({tag, " product"}, st_p(w), expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold p"}, st_p(w), expv);
      chk({tag, " hold valid/ready"}, {126'd0, st_ov(w), st_ir(w)}, 128'b10);
    end
    drive_or(w, 1'b1);
    @(negedge clk);
    drive_or(w, 1'b0);
    chk({tag, " drained"}, {126'd0, st_ov(w), st_ir(w)}, 128'b01);
  endtask

  function automatic logic [63:0] pick(input int w);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1 << (w - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int widths[3];
    int counts[3];
    int seen;
    widths = '{8, 16, 64};
    counts = '{300, 300, 120};
    rst = 1'b1;
    drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);  drive_or(8, 1'b0);
    drive_in(16, 1'b0, 64'd0, 64'd0, 1'b0); drive_or(16, 1'b0);
    drive_in(64, 1'b0, 64'd0, 64'd0, 1'b0); drive_or(64, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset flags", {125'd0, st_ir(widths[k]), st_ov(widths[k]), st_busy(widths[k])}, 128'b100);
      chk("reset p", st_p(widths[k]), 128'd0);
    end
    rst = 1'b0;

    run_op(8, 64'h80, 64'h80, 1'b1, 0, 0, "w8 s 80x80");
    chk("w8 s 80x80 literal", ref_mul(8, 64'h80, 64'h80, 1'b1), 128'h4000);
    run_op(8, 64'hFF, 64'hFF, 1'b0, 1, 0, "w8 u FFxFF");
    chk("w8 u FFxFF literal", ref_mul(8, 64'hFF, 64'hFF, 1'b0), 128'hFE01);
    run_op(8, 64'hFF, 64'hFF, 1'b1, 0, 1, "w8 s FFxFF");
    run_op(8, 64'hFF, 64'h01, 1'b1, 0, 0, "w8 s FFx01");
    run_op(64, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0, 0, "w64 s minxmin");
    chk("w64 minxmin literal", ref_mul(64, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1),
        128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run_op(8, 64'h5A, 64'hC3, 1'b1, 0, 10, "w8 backpressure");

    // Reset while digit 3 is about to retire.
    drive_in(8, 1'b1, 64'h7B, 64'h6D, 1'b0);
    @(negedge clk);
    drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid-busy flags", {125'd0, ir8, ov8, b8}, 128'b100);
    chk("rst mid-busy p", 128'(p8), 128'd0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (ov8) seen++; end
    chk("rst mid-busy no valid", 128'(seen), 128'd0);
    run_op(8, 64'd3, 64'd5, 1'b0, 0, 0, "w8 u 3x5");

    // Reset while a product waits for out_ready.
    drive_in(16, 1'b1, 64'h1234, 64'h5678, 1'b0);
    @(negedge clk);
    drive_in(16, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (12) @(negedge clk);
    chk("w16 waiting in done", 128'(ov16), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst in done flags", {125'd0, ir16, ov16, b16}, 128'b100);

    // in_valid during reset must not be taken.
    rst = 1'b1;
    drive_in(8, 1'b1, 64'd9, 64'd9, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_in(8, 1'b0, 64'd0, 64'd0, 1'b0);
    chk("no accept in reset", {126'd0, ir8, b8}, 128'b10);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < counts[k]; n++) begin
        run_op(widths[k], pick(widths[k]), pick(widths[k]), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rand w%0d #%0d", widths[k], n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
